// File: rtl/data_mem_responder.sv
// Data-port memory responder: WAIT_CYCLES wait states between accept and a registered response.
// Define DMEM_BYTE_LANES_EN to honour Req_byte_en on stores; otherwise stores write the whole word.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Req_valid,
  output logic        Req_ready,
  input  logic        Req_write,
  input  logic [31:0] Req_addr,
  input  logic [31:0] Req_wdata,
  input  logic [3:0]  Req_byte_en,
  output logic        Resp_valid,
  input  logic        Resp_ready,
  output logic [31:0] Resp_rdata,
  output logic        Resp_error
);
  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [3:0]       wait_cnt;
  logic             lat_write;
  logic             lat_error;
  logic [IDX_W-1:0] lat_idx;
  logic [31:0]      lat_wdata;
  logic [3:0]       lat_byte_en;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic             commit;
  logic             req_error;
  logic             c_write;
  logic             c_error;
  logic [IDX_W-1:0] c_idx;
  logic [31:0]      c_wdata;
  logic [3:0]       c_byte_en;
  logic [31:0]      c_mask;

  assign accept    = Req_valid & Req_ready;
  assign req_error = (Req_addr[1:0] != 2'b00) | (Req_addr[31:2] >= DEPTH_LIM);

  // With zero wait states the access commits on the accepting edge, straight from the request port.
  assign commit = (state == S_IDLE) ? (accept && (WAIT_CYCLES == 0))
                                    : ((state == S_WAIT) && (wait_cnt == 4'd1));

  always_comb begin
    c_write   = lat_write;
    c_error   = lat_error;
    c_idx     = lat_idx;
    c_wdata   = lat_wdata;
    c_byte_en = lat_byte_en;
    if (state == S_IDLE) begin
      c_write   = Req_write;
      c_error   = req_error;
      c_idx     = Req_addr[IDX_W+1:2];
      c_wdata   = Req_wdata;
      c_byte_en = Req_byte_en;
    end
  end

`ifdef DMEM_BYTE_LANES_EN
  assign c_mask = {{8{c_byte_en[3]}}, {8{c_byte_en[2]}}, {8{c_byte_en[1]}}, {8{c_byte_en[0]}}};
`else
  logic byte_en_unused;
  assign byte_en_unused = ^c_byte_en;
  assign c_mask         = 32'hFFFF_FFFF;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= S_IDLE;
      wait_cnt    <= 4'd0;
      Req_ready   <= 1'b1;
      Resp_valid  <= 1'b0;
      Resp_rdata  <= 32'h0;
      Resp_error  <= 1'b0;
      lat_write   <= 1'b0;
      lat_error   <= 1'b0;
      lat_idx     <= '0;
      lat_wdata   <= 32'h0;
      lat_byte_en <= 4'h0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= 32'h0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_write   <= Req_write;
            lat_error   <= req_error;
            lat_idx     <= Req_addr[IDX_W+1:2];
            lat_wdata   <= Req_wdata;
            lat_byte_en <= Req_byte_en;
            Req_ready   <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              wait_cnt <= WAIT_LOAD;
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (Resp_ready) begin
            state      <= S_IDLE;
            Req_ready  <= 1'b1;
            Resp_valid <= 1'b0;
            Resp_rdata <= 32'h0;
            Resp_error <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (commit) begin
        Resp_valid <= 1'b1;
        Resp_error <= c_error;
        Resp_rdata <= (c_write || c_error) ? 32'h0 : mem[c_idx];
        if (c_write && !c_error) begin
          mem[c_idx] <= (mem[c_idx] & ~c_mask) | (c_wdata & c_mask);
        end
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;
  localparam int W = 2;

`ifdef DMEM_BYTE_LANES_EN
  localparam bit LANES = 1'b1;
`else
  localparam bit LANES = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Req_valid, Req_ready, Req_write;
  logic [31:0] Req_addr, Req_wdata;
  logic [3:0]  Req_byte_en;
  logic        Resp_valid, Resp_ready, Resp_error;
  logic [31:0] Resp_rdata;

  logic        zreq_valid, zreq_ready, zreq_write;
  logic [31:0] zreq_addr, zreq_wdata;
  logic [3:0]  zreq_byte_en;
  logic        zresp_valid, zresp_ready, zresp_error;
  logic [31:0] zresp_rdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [256];

  always #5 CLK = ~CLK;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) dut (
    .CLK(CLK), .RESET(RESET),
    .Req_valid(Req_valid), .Req_ready(Req_ready), .Req_write(Req_write),
    .Req_addr(Req_addr), .Req_wdata(Req_wdata), .Req_byte_en(Req_byte_en),
    .Resp_valid(Resp_valid), .Resp_ready(Resp_ready),
    .Resp_rdata(Resp_rdata), .Resp_error(Resp_error)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_z (
    .CLK(CLK), .RESET(RESET),
    .Req_valid(zreq_valid), .Req_ready(zreq_ready), .Req_write(zreq_write),
    .Req_addr(zreq_addr), .Req_wdata(zreq_wdata), .Req_byte_en(zreq_byte_en),
    .Resp_valid(zresp_valid), .Resp_ready(zresp_ready),
    .Resp_rdata(zresp_rdata), .Resp_error(zresp_error)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // Reference: a word array; misaligned or beyond-256-word addresses are errors and touch nothing.
  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be, output logic [31:0] r, output logic e);
    logic [31:0] word;
    e = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
    r = 32'h0;
    if (!e) begin
      word = model[a[9:2]];
      if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (!LANES || be[i]) word[8*i +: 8] = d[8*i +: 8];
        end
        model[a[9:2]] = word;
      end else begin
        r = word;
      end
    end
  endtask

  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int hold, input bit pend);
    logic [31:0] er;
    logic        ee;
    int          n;
    int          lat;
    Req_valid   = 1'b1;
    Req_write   = w;
    Req_addr    = a;
    Req_wdata   = d;
    Req_byte_en = be;
    n = 0;
    while (Req_ready !== 1'b1 && n < 50) begin
      step;
      n++;
    end
    if (Req_ready !== 1'b1) begin
      chk1("accept_timeout", Req_ready, 1'b1);
      Req_valid = 1'b0;
      return;
    end
    step;
    // Scramble the request port after acceptance; the responder must use its latched copy.
    Req_valid   = 1'b0;
    Req_write   = 1'($urandom_range(0, 1));
    Req_addr    = $urandom;
    Req_wdata   = $urandom;
    Req_byte_en = 4'($urandom_range(0, 15));
    model_access(w, a, d, be, er, ee);
    lat = 1;
    while (Resp_valid !== 1'b1 && lat < 40) begin
      step;
      lat++;
    end
    chk32("latency", 32'(lat), 32'(W + 1));
    chk1("busy_req_ready", Req_ready, 1'b0);
    chk32("resp_rdata", Resp_rdata, er);
    chk1("resp_error", Resp_error, ee);
    for (int i = 0; i < hold; i++) begin
      if (pend) begin
        Req_valid = 1'b1;
        Req_write = 1'b0;
        Req_addr  = 32'h20;
      end
      step;
      chk1("hold_valid", Resp_valid, 1'b1);
      chk32("hold_rdata", Resp_rdata, er);
      chk1("hold_error", Resp_error, ee);
      chk1("hold_req_ready", Req_ready, 1'b0);
    end
    Resp_ready = 1'b1;
    step;
    Resp_ready = 1'b0;
    chk1("post_valid", Resp_valid, 1'b0);
    chk1("post_req_ready", Req_ready, 1'b1);
    chk32("post_rdata", Resp_rdata, 32'h0);
    chk1("post_error", Resp_error, 1'b0);
  endtask

  logic [31:0] zt_addr  [6] = '{32'h04, 32'h08, 32'h04, 32'h08, 32'h0C, 32'h06};
  logic [31:0] zt_wdata [6] = '{32'h0BAD_F00D, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'h0};
  logic        zt_write [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] zt_rdata [6] = '{32'h0, 32'h0, 32'h0BAD_F00D, 32'h1234_5678, 32'h0, 32'h0};
  logic        zt_error [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [31:0] a;
    int          sel;
    RESET        = 1'b0;
    Req_valid    = 1'b0;
    Req_write    = 1'b0;
    Req_addr     = 32'h0;
    Req_wdata    = 32'h0;
    Req_byte_en  = 4'h0;
    Resp_ready   = 1'b0;
    zreq_valid   = 1'b0;
    zreq_write   = 1'b0;
    zreq_addr    = 32'h0;
    zreq_wdata   = 32'h0;
    zreq_byte_en = 4'hF;
    zresp_ready  = 1'b1;
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
    repeat (3) step;
    chk1("rst_req_ready", Req_ready, 1'b1);
    chk1("rst_resp_valid", Resp_valid, 1'b0);
    chk32("rst_resp_rdata", Resp_rdata, 32'h0);
    chk1("rst_resp_error", Resp_error, 1'b0);
    chk1("rst_z_ready", zreq_ready, 1'b1);
    chk1("rst_z_valid", zresp_valid, 1'b0);
    RESET = 1'b1;
    step;

    do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    do_txn(1'b1, 32'h20, 32'hAABB_CCDD, 4'hF, 0, 1'b0);
    do_txn(1'b1, 32'h20, 32'h1122_3344, 4'b0101, 0, 1'b0);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 1, 1'b0);
    do_txn(1'b1, 32'h24, 32'h7777_7777, 4'b0000, 0, 1'b0);
    do_txn(1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0);
    do_txn(1'b0, 32'h13, 32'h0, 4'h0, 0, 1'b0);
    do_txn(1'b0, 32'h400, 32'h0, 4'h0, 0, 1'b0);
    do_txn(1'b1, 32'h401, 32'h9999_9999, 4'hF, 0, 1'b0);
    do_txn(1'b0, 32'h00, 32'h0, 4'h0, 0, 1'b0);
    // Held response with a second request already waiting; it goes in one cycle after the handshake.
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);

    Req_valid   = 1'b1;
    Req_write   = 1'b1;
    Req_addr    = 32'h08;
    Req_wdata   = 32'h55;
    Req_byte_en = 4'hF;
    step;
    Req_valid = 1'b0;
    chk1("mid_wait_req_ready", Req_ready, 1'b0);
    RESET = 1'b0;
    #1;
    chk1("abort_req_ready", Req_ready, 1'b1);
    chk1("abort_resp_valid", Resp_valid, 1'b0);
    chk32("abort_resp_rdata", Resp_rdata, 32'h0);
    chk1("abort_resp_error", Resp_error, 1'b0);
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
    step;
    RESET = 1'b1;
    step;
    do_txn(1'b0, 32'h08, 32'h0, 4'h0, 0, 1'b0);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
      else if (sel == 1) a = 32'h400 + 32'($urandom_range(0, 4095)) * 4;
      else               a = 32'($urandom_range(0, 15)) * 4;
      do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), 1'b0);
    end

    zreq_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      zreq_write = zt_write[i];
      zreq_addr  = zt_addr[i];
      zreq_wdata = zt_wdata[i];
      chk1("z_ready_idle", zreq_ready, 1'b1);
      step;
      chk1("z_valid_next", zresp_valid, 1'b1);
      chk1("z_ready_busy", zreq_ready, 1'b0);
      chk32("z_rdata", zresp_rdata, zt_rdata[i]);
      chk1("z_error", zresp_error, zt_error[i]);
      step;
      chk1("z_valid_clear", zresp_valid, 1'b0);
    end
    zreq_valid = 1'b0;
    step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the data port of the MIPS core. It accepts load and store requests over a valid/ready request channel and applies a fixed, configurable number of wait states. It then returns the read data and an error flag over a valid/ready response channel. It replaces the zero-latency combinational data memory when the core is built with a stalling memory interface, and it is the target end of the core's data-request initiator.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; word index = Req_addr[31:2]
- WAIT_CYCLES, 2: wait states between acceptance and response, legal 0..15
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset (0 = in reset)
- Req_valid  in  1  initiator has a request
- Req_ready  out  1  responder can accept
- Req_write  in  1  1 = store, 0 = load
- Req_addr  in  32  byte address
- Req_wdata  in  32  store data
- Req_byte_en  in  4  store byte lanes, bit i = bits [8i+7:8i]
- Resp_valid  out  1  response available
- Resp_ready  in  1  initiator takes response
- Resp_rdata  out  32  load data; 0 for stores and errors
- Resp_error  out  1  misaligned or out-of-range request

## Operation
- FSM with states IDLE, WAIT, RESP; reset state is IDLE.
- Reset values: Req_ready=1, Resp_valid=0, Resp_rdata=0, Resp_error=0, wait counter=0. All memory words clear to 0.
- **IDLE**
  - Req_ready=1.
  - On Req_valid&Req_ready, latch write, addr, wdata and byte_en.
  - Compute error = (addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS).
  - If WAIT_CYCLES=0, go to RESP; otherwise load counter=WAIT_CYCLES and go to WAIT.
- **WAIT**
  - Req_ready=0.
  - Counter decrements each cycle.
  - On the edge where counter==1, go to RESP.
- **Entry to RESP**
  - The access commits on this edge.
  - Load: Resp_rdata = mem[index].
  - Store: mem[index] lanes with byte_en=1 are updated; Resp_rdata=0.
  - Error: memory is untouched, Resp_rdata=0, Resp_error=1.
- **RESP**
  - Resp_valid=1; Resp_rdata and Resp_error are held stable until Resp_valid&Resp_ready.
  - On that handshake, go to IDLE and clear Resp_valid, Resp_rdata and Resp_error.
- Req_ready is 0 in WAIT and RESP. Requests presented there are ignored and are not buffered; the initiator must hold them.
- Req_* changes after acceptance have no effect, because the request is latched.
- A store with byte_en=4'b0000 still responds normally with no memory change.
- Reset asserted mid-transaction aborts it. If the commit edge has not yet occurred, no store is performed. The FSM returns to IDLE.

## Timing
- Acceptance at clock edge k causes the commit edge k+WAIT_CYCLES (k itself when WAIT_CYCLES=0).
- Resp_valid is high from edge k+WAIT_CYCLES.
- Resp_valid is visible WAIT_CYCLES+1 cycles after the cycle in which Req_valid&Req_ready was sampled.
- Response handshake at edge m means Req_ready=1 from edge m. The next acceptance is at the earliest at edge m+1, so there is no same-cycle response/accept overlap.
- Minimum issue interval is WAIT_CYCLES+2 cycles with Resp_ready tied high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- DMEM_BYTE_LANES_EN defined: stores honour Req_byte_en per lane.
- DMEM_BYTE_LANES_EN undefined: Req_byte_en is ignored and every non-error store writes all 32 bits.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10 and load 0x10 with WAIT_CYCLES=2. Required: load response 0xDEADBEEF, Resp_error=0, Resp_valid exactly 3 cycles after each acceptance cycle.
- With DMEM_BYTE_LANES_EN defined, store 0x11223344 to 0x20 with byte_en=4'b0101 over a word of 0xAABBCCDD. Required: load returns 0xAA22CC44. With the macro undefined, the load returns 0x11223344.
- Load from 0x13 (misaligned) and from 0x400 (DEPTH_WORDS=256). Required: Resp_error=1 and Resp_rdata=0 for both. A following load of 0x00 returns 0 with Resp_error=0.
- Hold Resp_ready=0 for 5 cycles in RESP. Required: Resp_valid, Resp_rdata and Resp_error are stable. Req_ready=0 throughout, and a second Req_valid is not accepted until 1 cycle after the response handshake.
- Drive RESET low during WAIT of a store of 0x55 to 0x08. Required: all outputs return to reset values immediately, and a load of 0x08 afterwards returns 0.
- WAIT_CYCLES=0 with back-to-back loads and Resp_ready tied high. Required: Resp_valid 1 cycle after each acceptance, one transaction every 2 cycles.
